// File: rtl/wireframe_buffer_ctrl_pkg.sv
// Shared sizes and state types for the double-buffered wireframe sequencer.
package wireframe_buffer_ctrl_pkg;

  localparam int WIDTH               = 160;
  localparam int HEIGHT              = 120;
  localparam int WIREFRAME_ADDR_SIZE = $clog2(WIDTH * HEIGHT);

  typedef logic [WIREFRAME_ADDR_SIZE-1:0] wf_addr_t;

  typedef enum logic [1:0] {W_CLEAR, W_DRAW, W_SWAP} wf_wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_PRIME, R_STREAM} wf_rstate_t;

endpackage

// File: rtl/wireframe_scan.sv
// Front-buffer reader: primes the registered SRAM read, then streams pixels
// with valid/ready, tracking the linear address and x/y without a multiplier.
module wireframe_scan
  import wireframe_buffer_ctrl_pkg::*;
#(
  parameter  int WIDTH  = 4,
  parameter  int HEIGHT = 3,
  parameter  int AW     = 4,
  localparam int XW     = $clog2(WIDTH),
  localparam int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          flip,
  input  logic          pix_ready,
  input  logic          sram_data_out,
  output logic          pix_valid,
  output logic          pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_last,
  output logic [AW-1:0] read_addr,
  output logic          idle
);

  localparam int            N    = WIDTH * HEIGHT;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  wf_rstate_t    state, state_next;
  logic [AW-1:0] cur;
  logic          handshake;

  assign pix_valid = (state == R_STREAM);
  assign pix_last  = pix_valid && (cur == LAST);
  assign pix_data  = sram_data_out;
  assign handshake = pix_valid && pix_ready;
  assign idle      = (state == R_IDLE);

  // The read address looks one pixel ahead on a handshake so the registered
  // SRAM output already holds the next pixel when it is presented.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next = state;
    read_addr  = '0;
    case (state)
      R_IDLE:   if (flip) state_next = R_PRIME;
      R_PRIME:  state_next = R_STREAM;
      R_STREAM: begin
        read_addr = cur;
        if (handshake) begin
          if (pix_last) state_next = R_IDLE;
          else          read_addr  = cur + 1'b1;
        end
      end
      default:  state_next = R_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= R_IDLE;
      cur   <= '0;
      pix_x <= '0;
      pix_y <= '0;
    end else begin
      state <= state_next;
      if (state == R_PRIME || (handshake && pix_last)) begin
        cur   <= '0;
        pix_x <= '0;
        pix_y <= '0;
      end else if (handshake) begin
        cur <= cur + 1'b1;
        if (pix_x == XW'(WIDTH - 1)) begin
          pix_x <= '0;
          pix_y <= pix_y + 1'b1;
        end else begin
          pix_x <= pix_x + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wireframe_buffer_ctrl.sv
// Sequencer for the double-buffered wireframe SRAM: clears the back buffer,
// passes drawer writes through, and flips only when drawer and reader are done.
module wireframe_buffer_ctrl
  import wireframe_buffer_ctrl_pkg::*;
#(
  parameter  int WIDTH  = wireframe_buffer_ctrl_pkg::WIDTH,
  parameter  int HEIGHT = wireframe_buffer_ctrl_pkg::HEIGHT,
  parameter  int AW     = WIREFRAME_ADDR_SIZE,
  localparam int XW     = $clog2(WIDTH),
  localparam int YW     = $clog2(HEIGHT)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          draw_req,
  input  logic [AW-1:0] draw_addr,
  input  logic          draw_data,
  output logic          draw_ready,
  output logic          draw_ack,
  input  logic          frame_done,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic          pix_data,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_last,
  output logic          sram_write_en,
  output logic          sram_data_in,
  output logic [AW-1:0] sram_write_addr,
  output logic [AW-1:0] sram_read_addr,
  output logic          sram_flip,
  input  logic          sram_data_out,
  output logic [7:0]    frame_count
);

  localparam int            N    = WIDTH * HEIGHT;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  wf_wstate_t    w_state, w_state_next;
  logic [AW-1:0] clr_addr;
  logic          reader_idle;

  assign draw_ack = draw_req && draw_ready;

  always_comb begin
    w_state_next    = w_state;
    draw_ready      = 1'b0;
    sram_write_en   = 1'b0;
    sram_data_in    = 1'b0;
    sram_write_addr = clr_addr;
    sram_flip       = 1'b0;
    case (w_state)
      W_CLEAR: begin
        sram_write_en = 1'b1;
        if (clr_addr == LAST) w_state_next = W_DRAW;
      end
      W_DRAW: begin
        draw_ready      = 1'b1;
        sram_write_en   = draw_req;
        sram_write_addr = draw_addr;
        sram_data_in    = draw_data;
        if (frame_done) w_state_next = W_SWAP;
      end
      // Swap waits for the reader so a frame is never torn mid-stream.
      W_SWAP: begin
        if (reader_idle) begin
          sram_flip    = 1'b1;
          w_state_next = W_CLEAR;
        end
      end
      default: w_state_next = W_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      w_state     <= W_CLEAR;
      clr_addr    <= '0;
      frame_count <= '0;
    end else begin
      w_state <= w_state_next;
      if (w_state == W_CLEAR) clr_addr <= (clr_addr == LAST) ? '0 : clr_addr + 1'b1;
      if (sram_flip) begin
        frame_count <= frame_count + 1'b1;
        clr_addr    <= '0;
      end
    end
  end

  wireframe_scan #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .AW     (AW)
  ) u_scan (
    .clk           (clk),
    .n_rst         (n_rst),
    .flip          (sram_flip),
    .pix_ready     (pix_ready),
    .sram_data_out (sram_data_out),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_x         (pix_x),
    .pix_y         (pix_y),
    .pix_last      (pix_last),
    .read_addr     (sram_read_addr),
    .idle          (reader_idle)
  );

endmodule
